// File: rtl/count_watch.sv
// Watches an accumulating counter for reaching or stepping over a threshold (wrap-aware).
// Latency: a count presented before edge N+1 is reflected in hit/flag/hits after edge N+1; no backpressure.
module count_watch #(
  parameter int WIDTH      = 8,
  parameter int HITS_W     = 4,
  parameter int AUTO_REARM = 0
) (
  input  logic              ck,
  input  logic              clr,
  input  logic [WIDTH-1:0]  count,
  input  logic [WIDTH-1:0]  cmp,
  input  logic              arm,
  input  logic              ack,
  output logic              hit,
  output logic              flag,
  output logic              wrap,
  output logic [HITS_W-1:0] hits,
  output logic              busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] PENDING = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] prev;
  logic             pv;
  logic             wr;
  logic             xing;
  logic             fire;

  always_comb begin
    wr   = pv & (count < prev);
    // On a wrap the travelled range is (prev, max] plus [0, count].
    if (wr) begin
      xing = (prev < cmp) | (cmp <= count);
    end else begin
      xing = pv & (prev < cmp) & (cmp <= count);
    end
    fire = (state == ARMED) & arm & xing;

    state_nxt = state;
    case (state)
      IDLE: begin
        if (arm) state_nxt = ARMED;
      end
      ARMED: begin
        if (!arm) begin
          state_nxt = IDLE;
        end else if (fire) begin
          state_nxt = (AUTO_REARM != 0) ? ARMED : PENDING;
        end
      end
      PENDING: begin
        if (ack) state_nxt = arm ? ARMED : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (clr) begin
      state <= IDLE;
      prev  <= '0;
      pv    <= 1'b0;
      hit   <= 1'b0;
      flag  <= 1'b0;
      wrap  <= 1'b0;
      hits  <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      prev  <= count;
      // Invalidate history on arming so a count already past cmp cannot hit.
      pv    <= !((state == IDLE) && arm);
      hit   <= fire;
      if (fire) begin
        flag <= 1'b1;
      end else if (ack) begin
        flag <= 1'b0;
      end
      if (wr) begin
        wrap <= 1'b1;
      end else if (ack) begin
        wrap <= 1'b0;
      end
      if (fire && (hits != '1)) begin
        hits <= hits + 1'b1;
      end
      busy  <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_count_watch.sv
// Bench for count_watch: directed vector table, auto-rearm laps and a randomized scoreboard run.
module tb_count_watch;

  logic       ck = 1'b0;
  logic       clr;
  logic [7:0] count;
  logic [7:0] cmp;
  logic       arm;
  logic       ack;

  logic       hit0, flag0, wrap0, busy0;
  logic [3:0] hits0;
  logic       hit1, flag1, wrap1, busy1;
  logic [3:0] hits1;

  int checks = 0;
  int fails  = 0;

  always #5 ck = ~ck;

  count_watch #(.WIDTH(8), .HITS_W(4), .AUTO_REARM(0)) u_dut0 (
    .ck(ck), .clr(clr), .count(count), .cmp(cmp), .arm(arm), .ack(ack),
    .hit(hit0), .flag(flag0), .wrap(wrap0), .hits(hits0), .busy(busy0)
  );

  count_watch #(.WIDTH(8), .HITS_W(4), .AUTO_REARM(1)) u_dut1 (
    .ck(ck), .clr(clr), .count(count), .cmp(cmp), .arm(arm), .ack(ack),
    .hit(hit1), .flag(flag1), .wrap(wrap1), .hits(hits1), .busy(busy1)
  );

  // Reference model: 0 = idle, 1 = watching, 2 = waiting for ack. Index = AUTO_REARM.
  int       m_st   [2];
  int       m_prev [2];
  bit       m_pv   [2];
  bit       m_hit  [2];
  bit       m_flag [2];
  bit       m_wrap [2];
  int       m_hits [2];
  bit       m_busy [2];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    int  d, o, nst;
    bit  wrapped, crossed, fire;
    for (int r = 0; r < 2; r++) begin
      if (clr) begin
        m_st[r] = 0; m_prev[r] = 0; m_pv[r] = 0;
        m_hit[r] = 0; m_flag[r] = 0; m_wrap[r] = 0; m_hits[r] = 0; m_busy[r] = 0;
      end else begin
        // Distance travelled forward on the mod-256 circle, and offset of cmp from prev.
        d       = (int'(count) - m_prev[r] + 256) % 256;
        o       = (int'(cmp) - m_prev[r] + 256) % 256;
        wrapped = m_pv[r] && (int'(count) < m_prev[r]);
        crossed = m_pv[r] && (d != 0) && (o >= 1) && (o <= d);
        fire    = (m_st[r] == 1) && arm && crossed;
        nst     = m_st[r];
        if (m_st[r] == 0) begin
          if (arm) nst = 1;
        end else if (m_st[r] == 1) begin
          if (!arm) nst = 0;
          else if (fire) nst = (r == 1) ? 1 : 2;
        end else begin
          if (ack) nst = arm ? 1 : 0;
        end
        m_hit[r]  = fire;
        m_flag[r] = fire ? 1'b1 : (ack ? 1'b0 : m_flag[r]);
        m_wrap[r] = wrapped ? 1'b1 : (ack ? 1'b0 : m_wrap[r]);
        if (fire && m_hits[r] < 15) m_hits[r] = m_hits[r] + 1;
        m_pv[r]   = !((m_st[r] == 0) && arm);
        m_st[r]   = nst;
        m_busy[r] = (nst != 0);
        m_prev[r] = int'(count);
      end
    end
  endtask

  task automatic scoreboard();
    check("sb0_hit",  hit0,  m_hit[0]);
    check("sb0_flag", flag0, m_flag[0]);
    check("sb0_wrap", wrap0, m_wrap[0]);
    check("sb0_hits", hits0, m_hits[0]);
    check("sb0_busy", busy0, m_busy[0]);
    check("sb1_hit",  hit1,  m_hit[1]);
    check("sb1_flag", flag1, m_flag[1]);
    check("sb1_wrap", wrap1, m_wrap[1]);
    check("sb1_hits", hits1, m_hits[1]);
    check("sb1_busy", busy1, m_busy[1]);
  endtask

  task automatic drive(logic c, logic [7:0] cnt, logic [7:0] cm, logic a, logic k);
    clr = c; count = cnt; cmp = cm; arm = a; ack = k;
  endtask

  task automatic tick();
    @(posedge ck);
    model_step();
    #1;
    scoreboard();
  endtask

  typedef struct {
    logic       clr;
    logic [7:0] count;
    logic [7:0] cmp;
    logic       arm;
    logic       ack;
    logic       hit;
    logic       flag;
    logic       wrap;
    logic [3:0] hits;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic c, logic [7:0] cnt, logic [7:0] cm, logic a, logic k,
                              logic h, logic f, logic w, logic [3:0] n, logic b);
    vec_t v;
    v.clr = c; v.count = cnt; v.cmp = cm; v.arm = a; v.ack = k;
    v.hit = h; v.flag = f; v.wrap = w; v.hits = n; v.busy = b;
    tbl.push_back(v);
  endfunction

  int pulses;

  initial begin
    drive(1'b1, 8'd0, 8'd5, 1'b1, 1'b1);

    // Reset held with arm/ack high, then arm takes effect one edge after release.
    add(1, 0, 5, 1, 1,  0, 0, 0, 0, 0);
    add(1, 0, 5, 1, 1,  0, 0, 0, 0, 0);
    add(0, 0, 5, 1, 0,  0, 0, 0, 0, 1);
    // Step 1 towards cmp=5: exactly one hit, then pending until ack.
    add(0, 1, 5, 1, 0,  0, 0, 0, 0, 1);
    add(0, 2, 5, 1, 0,  0, 0, 0, 0, 1);
    add(0, 3, 5, 1, 0,  0, 0, 0, 0, 1);
    add(0, 4, 5, 1, 0,  0, 0, 0, 0, 1);
    add(0, 5, 5, 1, 0,  1, 1, 0, 1, 1);
    add(0, 6, 5, 1, 0,  0, 1, 0, 1, 1);
    add(0, 7, 5, 1, 0,  0, 1, 0, 1, 1);
    add(0, 8, 5, 1, 0,  0, 1, 0, 1, 1);
    add(0, 9, 5, 1, 0,  0, 1, 0, 1, 1);
    add(0, 9, 5, 1, 1,  0, 0, 0, 1, 1);
    add(0, 9, 5, 1, 0,  0, 0, 0, 1, 1);
    // Step 3 over cmp=7 without landing on it.
    add(1, 3, 7, 1, 0,  0, 0, 0, 0, 0);
    add(0, 3, 7, 1, 0,  0, 0, 0, 0, 1);
    add(0, 3, 7, 1, 0,  0, 0, 0, 0, 1);
    add(0, 6, 7, 1, 0,  0, 0, 0, 0, 1);
    add(0, 9, 7, 1, 0,  1, 1, 0, 1, 1);
    add(0, 9, 7, 1, 1,  0, 0, 0, 1, 1);
    // Wrap-around with cmp=2: wrap on 253->0, hit on 0->3, one ack clears both.
    add(0, 250, 2, 1, 0,  0, 0, 0, 1, 1);
    add(0, 253, 2, 1, 0,  0, 0, 0, 1, 1);
    add(0, 0,   2, 1, 0,  0, 0, 1, 1, 1);
    add(0, 3,   2, 1, 0,  1, 1, 1, 2, 1);
    add(0, 3,   2, 1, 1,  0, 0, 0, 2, 1);
    // Same wrap while disarmed: wrap still flagged, no hit.
    add(0, 250, 2, 0, 0,  0, 0, 0, 2, 0);
    add(0, 253, 2, 0, 0,  0, 0, 0, 2, 0);
    add(0, 0,   2, 0, 0,  0, 0, 1, 2, 0);
    add(0, 3,   2, 0, 0,  0, 0, 1, 2, 0);
    add(0, 3,   2, 0, 1,  0, 0, 0, 2, 0);
    // Arm with a stalled count already above cmp, then move cmp: never a hit.
    add(0, 200, 100, 0, 0,  0, 0, 0, 2, 0);
    for (int i = 0; i < 11; i++) add(0, 200, 100, 1, 0,  0, 0, 0, 2, 1);
    for (int i = 0; i < 3; i++)  add(0, 200, 150, 1, 0,  0, 0, 0, 2, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].clr, tbl[i].count, tbl[i].cmp, tbl[i].arm, tbl[i].ack);
      tick();
      check($sformatf("tbl%0d_hit", i),  hit0,  tbl[i].hit);
      check($sformatf("tbl%0d_flag", i), flag0, tbl[i].flag);
      check($sformatf("tbl%0d_wrap", i), wrap0, tbl[i].wrap);
      check($sformatf("tbl%0d_hits", i), hits0, tbl[i].hits);
      check($sformatf("tbl%0d_busy", i), busy0, tbl[i].busy);
    end

    // Auto-rearm: two laps give two hits; ack on the second hit edge loses to set.
    drive(1, 0, 3, 1, 0); tick();
    drive(0, 0, 3, 1, 0); tick();
    pulses = 0;
    for (int lap = 0; lap < 2; lap++) begin
      for (int c = 0; c < 256; c++) begin
        drive(0, 8'(c), 3, 1, (lap == 1) && (c == 3));
        tick();
        if (hit1) pulses++;
        if (lap == 1 && c == 3) check("rearm_set_wins_flag", flag1, 1);
      end
    end
    check("rearm_pulses_2laps", pulses, 2);
    check("rearm_hits_2laps", hits1, 2);
    check("rearm_busy", busy1, 1);
    drive(0, 255, 3, 1, 1); tick();
    check("rearm_ack_clears_flag", flag1, 0);
    for (int lap = 0; lap < 16; lap++) begin
      for (int c = 0; c < 256; c++) begin
        drive(0, 8'(c), 3, 1, 0);
        tick();
        if (hit1) pulses++;
      end
    end
    check("rearm_hits_saturated", hits1, 15);
    check("rearm_pulses_total", pulses, 18);

    // Randomized run against the model for both variants.
    drive(1, 0, 0, 0, 0); tick();
    for (int n = 0; n < 3000; n++) begin
      int sel;
      logic [7:0] nc;
      sel = $urandom_range(0, 9);
      if (sel <= 2)      nc = count;
      else if (sel <= 7) nc = count + 8'($urandom_range(1, 4));
      else if (sel == 8) nc = count + 8'($urandom_range(5, 60));
      else               nc = 8'($urandom_range(0, 255));
      drive($urandom_range(0, 99) == 0, nc,
            ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255)) : cmp,
            $urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
